id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//   ID/EX pipeline register and EX operand-select stage of the 5-stage MIPS core; drives ALU data1/data2/shamt/alu_ctrl.
//   Captures decoded operands and control, inserts bubbles, holds on stall, detects load-use hazards.
//   Resolves RAW hazards by forwarding from EX/MEM and MEM/WB into the ALU operands.
// PARAMETERS
//   XLEN      32  datapath width
//   RADDR_W   5   register index width
// PORTS
//   clk            in   1      rising-edge clock
//   rst            in   1      synchronous, active-high reset
//   id_valid       in   1      ID holds a real instruction
//   id_rs_data     in   XLEN   regfile read port A
//   id_rt_data     in   XLEN   regfile read port B
//   id_imm         in   XLEN   extended immediate
//   id_rs/id_rt/id_rd in RADDR_W  source/dest indices (id_rd already muxed rt/rd)
//   id_shamt       in   5      shift amount
//   id_alu_ctrl    in   4      ALU opcode (mips_pkg codes)
//   id_alu_src     in   1      1: data2 = imm
//   id_uses_rt     in   1      instruction reads rt (R-type, store, branch)
//   id_reg_write/id_mem_read/id_mem_write/id_mem_to_reg in 1  control bundle
//   stall          in   1      downstream hold request
//   flush          in   1      squash ID->EX transfer (branch/jump redirect)
//   mem_reg_write  in   1      EX/MEM writes a register;  mem_rd in RADDR_W;  mem_fwd_data in XLEN
//   wb_reg_write   in   1      MEM/WB writes a register;  wb_rd in RADDR_W;   wb_data in XLEN
//   ex_valid       out  1      EX holds a real instruction
//   ex_data1/ex_data2 out XLEN ALU operands;  ex_store_data out XLEN forwarded rt for stores
//   ex_shamt       out  6      {1'b0, shamt};  ex_alu_ctrl out 4
//   ex_rd          out  RADDR_W;  ex_reg_write/ex_mem_read/ex_mem_write/ex_mem_to_reg out 1
//   load_use_stall out  1      combinational; IF/ID must hold when high
// BEHAVIOUR
//   - Reset: all registers 0 -> ex_valid=0, ex_alu_ctrl=0 (ALU outputs 0), control 0, operands 0.
//   - Register update priority (per cycle): rst > flush > stall > load_use_stall > load.
//     flush: bubble (valid and control 0, alu_ctrl 0), even if stall=1.
//     stall: hold all fields; captured rs/rt values refresh with current forwarded values so a WB retiring during the hold is not lost.
//     load_use_stall (stall=0): bubble into EX; ID contents re-presented next cycle.
//     load: capture ID; 1-cycle latency ID->EX.
//   - ID-side bypass at capture: wb_reg_write && wb_rd==id_rs && id_rs!=0 -> capture wb_data (same for rt).
//   - load_use_stall = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
//   - Forwarding (comb, per operand src in {rs,rt}): EX/MEM match beats MEM/WB; match needs *_reg_write=1 and rd!=0; else captured value.
//   - ex_data1=fwd(rs); ex_data2 = alu_src ? imm : fwd(rt); ex_store_data=fwd(rt) always.
//   - Register $0: never forwarded, never triggers a hazard.
//   - rst mid-stall or with flush: reset wins; load_use_stall=0 the cycle after.
// CONFIGURATION
//   EX_FORWARD_EN defined: forwarding as above.
//   Undefined: ex_data1/2/store_data use captured values only; mem_*/wb_* forwarding inputs unused except ID-side bypass;
//     load_use_stall also asserts on any RAW vs EX (ex_reg_write) or MEM (mem_reg_write) dest, rd!=0.
// STRUCTURE
//   mips_pkg: ALU opcodes (ADD=1 SUB=2 AND=3 OR=4 XOR=5 LUI=6 SLT=7 SLL=8 SRL=9), REG_ZERO, XLEN, ctrl bundle struct.
//   Sub-module fwd_mux: (src idx, captured value, mem/wb fwd inputs) -> operand; instantiated for rs and rt.
// TESTING
//   1 rst=1 with id_valid=1 ADD -> next cycle ex_valid=0, ex_alu_ctrl=0, all outputs 0.
//   2 ADD $3<- ; next ADD $4,$3,$2 with mem_rd=3, mem_fwd_data=0x10, wb_rd=3, wb_data=0x20 -> ex_data1=0x10 (EX/MEM wins).
//   3 EX holds LW $5; ID ADD $6,$5,$1 -> load_use_stall=1, next cycle ex_valid=0, ADD lands one cycle later with
//     ex_data1 = wb_data of the load (MEM/WB forward).
//   4 stall=1 for 3 cycles while wb_rd=rs, wb_data=0xABCD retires in cycle 1 -> after release ex_data1=0xABCD.
//   5 flush=1 and stall=1 together -> ex_valid=0, ex_reg_write=0 next cycle.
//   6 mem_rd=0, mem_reg_write=1, mem_fwd_data=0xFFFF, id_rs=0, id_rs_data=0 -> ex_data1=0; SLL shamt=31 -> ex_shamt=6'd31.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core types: ALU opcodes, register-file constants and the
// control bundle carried from decode down the pipeline.
package mips_pkg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;

    localparam logic [RADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic [3:0] {
        ALU_NOP = 4'd0,
        ALU_ADD = 4'd1,
        ALU_SUB = 4'd2,
        ALU_AND = 4'd3,
        ALU_OR  = 4'd4,
        ALU_XOR = 4'd5,
        ALU_LUI = 4'd6,
        ALU_SLT = 4'd7,
        ALU_SLL = 4'd8,
        ALU_SRL = 4'd9
    } alu_op_e;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/fwd_mux.sv
// Operand bypass for one EX source register: the EX/MEM result beats the
// MEM/WB result, and register $0 is never bypassed.
module fwd_mux #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic [RADDR_W-1:0] src,
    input  logic [XLEN-1:0]    cap_data,
    input  logic               mem_reg_write,
    input  logic [RADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]    mem_fwd_data,
    input  logic               wb_reg_write,
    input  logic [RADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]    wb_data,
    output logic [XLEN-1:0]    operand
);

    function automatic logic dest_hit(input logic we,
                                      input logic [RADDR_W-1:0] rd,
                                      input logic [RADDR_W-1:0] idx);
        return we && (rd != '0) && (rd == idx);
    endfunction

    always_comb begin
        operand = cap_data;
        if (dest_hit(mem_reg_write, mem_rd, src)) begin
            operand = mem_fwd_data;
        end else if (dest_hit(wb_reg_write, wb_rd, src)) begin
            operand = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register and EX operand select with load-use detection.
// Define EX_FORWARD_EN to bypass EX/MEM and MEM/WB results into the ALU operands.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int XLEN    = mips_pkg::XLEN,
    parameter int RADDR_W = mips_pkg::RADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [XLEN-1:0]    id_rs_data,
    input  logic [XLEN-1:0]    id_rt_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic [RADDR_W-1:0] id_rs,
    input  logic [RADDR_W-1:0] id_rt,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic [4:0]         id_shamt,
    input  logic [3:0]         id_alu_ctrl,
    input  logic               id_alu_src,
    input  logic               id_uses_rt,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               id_mem_to_reg,
    input  logic               stall,
    input  logic               flush,
    input  logic               mem_reg_write,
    input  logic [RADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]    mem_fwd_data,
    input  logic               wb_reg_write,
    input  logic [RADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]    wb_data,
    output logic               ex_valid,
    output logic [XLEN-1:0]    ex_data1,
    output logic [XLEN-1:0]    ex_data2,
    output logic [XLEN-1:0]    ex_store_data,
    output logic [5:0]         ex_shamt,
    output logic [3:0]         ex_alu_ctrl,
    output logic [RADDR_W-1:0] ex_rd,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_mem_to_reg,
    output logic               load_use_stall
);

    function automatic logic dest_hit(input logic we,
                                      input logic [RADDR_W-1:0] rd,
                                      input logic [RADDR_W-1:0] idx);
        return we && (rd != '0) && (rd == idx);
    endfunction

    function automatic logic [XLEN-1:0] id_bypass(input logic [RADDR_W-1:0] idx,
                                                  input logic [XLEN-1:0] rf_data,
                                                  input logic we,
                                                  input logic [RADDR_W-1:0] rd,
                                                  input logic [XLEN-1:0] data);
        return dest_hit(we, rd, idx) ? data : rf_data;
    endfunction

    ctrl_t id_ctrl;
    assign id_ctrl = '{reg_write:  id_reg_write,
                       mem_read:   id_mem_read,
                       mem_write:  id_mem_write,
                       mem_to_reg: id_mem_to_reg};

    // ---- ID/EX boundary: _p1 registers hold the instruction in EX ----
    logic               vld_p1;
    ctrl_t              ctrl_p1;
    logic [3:0]         alu_ctrl_p1;
    logic               alu_src_p1;
    logic [RADDR_W-1:0] rs_p1;
    logic [RADDR_W-1:0] rt_p1;
    logic [RADDR_W-1:0] rd_p1;
    logic [4:0]         shamt_p1;
    logic [XLEN-1:0]    imm_p1;
    logic [XLEN-1:0]    rs_val_p1;
    logic [XLEN-1:0]    rt_val_p1;

    logic               mem_fwd_we;
    logic [XLEN-1:0]    rs_fwd;
    logic [XLEN-1:0]    rt_fwd;
    logic               raw_rs;
    logic               raw_rt;
    logic               take;

    fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs (
        .src           (rs_p1),
        .cap_data      (rs_val_p1),
        .mem_reg_write (mem_fwd_we),
        .mem_rd        (mem_rd),
        .mem_fwd_data  (mem_fwd_data),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .operand       (rs_fwd)
    );

    fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rt (
        .src           (rt_p1),
        .cap_data      (rt_val_p1),
        .mem_reg_write (mem_fwd_we),
        .mem_rd        (mem_rd),
        .mem_fwd_data  (mem_fwd_data),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .operand       (rt_fwd)
    );

`ifdef EX_FORWARD_EN
    assign mem_fwd_we    = mem_reg_write;
    assign ex_data1      = rs_fwd;
    assign ex_data2      = alu_src_p1 ? imm_p1 : rt_fwd;
    assign ex_store_data = rt_fwd;

    // Only a load in EX cannot be bypassed in time.
    always_comb begin
        raw_rs = dest_hit(vld_p1 && ctrl_p1.mem_read, rd_p1, id_rs);
        raw_rt = dest_hit(vld_p1 && ctrl_p1.mem_read, rd_p1, id_rt);
    end
`else
    // Without EX bypass the held instruction still picks up a WB retiring during a stall.
    assign mem_fwd_we    = 1'b0;
    assign ex_data1      = rs_val_p1;
    assign ex_data2      = alu_src_p1 ? imm_p1 : rt_val_p1;
    assign ex_store_data = rt_val_p1;

    always_comb begin
        raw_rs = dest_hit(vld_p1 && (ctrl_p1.reg_write || ctrl_p1.mem_read), rd_p1, id_rs)
              || dest_hit(mem_reg_write, mem_rd, id_rs);
        raw_rt = dest_hit(vld_p1 && (ctrl_p1.reg_write || ctrl_p1.mem_read), rd_p1, id_rt)
              || dest_hit(mem_reg_write, mem_rd, id_rt);
    end
`endif

    assign load_use_stall = id_valid && (raw_rs || (id_uses_rt && raw_rt));
    assign take           = id_valid && !flush && !load_use_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            ctrl_p1     <= CTRL_BUBBLE;
            alu_ctrl_p1 <= '0;
            alu_src_p1  <= 1'b0;
            rs_p1       <= '0;
            rt_p1       <= '0;
            rd_p1       <= '0;
            shamt_p1    <= '0;
            imm_p1      <= '0;
            rs_val_p1   <= '0;
            rt_val_p1   <= '0;
        end else if (stall && !flush) begin
            rs_val_p1   <= rs_fwd;
            rt_val_p1   <= rt_fwd;
        end else begin
            vld_p1      <= take;
            ctrl_p1     <= take ? id_ctrl : CTRL_BUBBLE;
            alu_ctrl_p1 <= take ? id_alu_ctrl : 4'd0;
            alu_src_p1  <= id_alu_src;
            rs_p1       <= id_rs;
            rt_p1       <= id_rt;
            rd_p1       <= id_rd;
            shamt_p1    <= id_shamt;
            imm_p1      <= id_imm;
            rs_val_p1   <= id_bypass(id_rs, id_rs_data, wb_reg_write, wb_rd, wb_data);
            rt_val_p1   <= id_bypass(id_rt, id_rt_data, wb_reg_write, wb_rd, wb_data);
        end
    end

    assign ex_valid      = vld_p1;
    assign ex_shamt      = {1'b0, shamt_p1};
    assign ex_alu_ctrl   = alu_ctrl_p1;
    assign ex_rd         = rd_p1;
    assign ex_reg_write  = ctrl_p1.reg_write;
    assign ex_mem_read   = ctrl_p1.mem_read;
    assign ex_mem_write  = ctrl_p1.mem_write;
    assign ex_mem_to_reg = ctrl_p1.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table for single transfers, plus
// hand sequences for bypass, load-use, stall, flush and reset corners.
`timescale 1ns/1ps
module tb_id_ex_stage;
    import mips_pkg::*;

`ifdef EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk, rst;
    logic        id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic [3:0]  id_alu_ctrl;
    logic        id_alu_src, id_uses_rt;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        stall, flush;
    logic        mem_reg_write, wb_reg_write;
    logic [4:0]  mem_rd, wb_rd;
    logic [31:0] mem_fwd_data, wb_data;
    logic        ex_valid;
    logic [31:0] ex_data1, ex_data2, ex_store_data;
    logic [5:0]  ex_shamt;
    logic [3:0]  ex_alu_ctrl;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic        load_use_stall;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
        .id_alu_ctrl(id_alu_ctrl), .id_alu_src(id_alu_src), .id_uses_rt(id_uses_rt),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .stall(stall), .flush(flush),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_fwd_data(mem_fwd_data),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_data1(ex_data1), .ex_data2(ex_data2),
        .ex_store_data(ex_store_data), .ex_shamt(ex_shamt), .ex_alu_ctrl(ex_alu_ctrl),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .load_use_stall(load_use_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    int n_checks;
    int n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [4:0] sh,
                           input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                           input logic [3:0] alu, input logic asrc, input logic urt,
                           input logic rw, input logic mr, input logic mw, input logic m2r);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_shamt = sh;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
        id_alu_ctrl = alu; id_alu_src = asrc; id_uses_rt = urt;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r;
    endtask

    task automatic idle_id();
        load_id(0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic idle_side();
        stall = 0; flush = 0;
        mem_reg_write = 0; mem_rd = 0; mem_fwd_data = 0;
        wb_reg_write = 0; wb_rd = 0; wb_data = 0;
    endtask

    typedef struct {
        logic v; logic [4:0] rs, rt, rd, sh;
        logic [31:0] rsd, rtd, imm;
        logic [3:0] alu; logic asrc, urt, rw, mr, mw, m2r;
        logic wbw; logic [4:0] wbrd; logic [31:0] wbd;
        logic [31:0] e_d1, e_d2, e_sd;
    } vec_t;

    vec_t vecs[11];

    int          got_k;
    logic [31:0] t3_d1;
    logic [4:0]  t3_rd;
    bit          take;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        //          v rs rt rd sh  rs_data       rt_data        imm            alu asrc urt rw mr mw m2r wbw wbrd wb_data     exp d1        exp d2         exp store
        vecs[0]  = '{1, 1, 2, 3, 0, 32'h11,       32'h22,        32'h99,        1, 0, 1, 1, 0, 0, 0, 0, 0,  32'h0,      32'h11,       32'h22,        32'h22};
        vecs[1]  = '{1, 4, 5, 5, 0, 32'h100,      32'h7,         32'hFFFFFFFC,  1, 1, 0, 1, 0, 0, 0, 0, 0,  32'h0,      32'h100,      32'hFFFFFFFC,  32'h7};
        vecs[2]  = '{1, 6, 7, 0, 0, 32'h2000,     32'hDEADBEEF,  32'h4,         1, 1, 1, 0, 0, 1, 0, 0, 0,  32'h0,      32'h2000,     32'h4,         32'hDEADBEEF};
        vecs[3]  = '{1, 8, 9, 9, 0, 32'h3000,     32'h55,        32'h8,         1, 1, 0, 1, 1, 0, 1, 0, 0,  32'h0,      32'h3000,     32'h8,         32'h55};
        vecs[4]  = '{1, 10, 11, 12, 0, 32'h1,     32'h2,         32'h0,         2, 0, 1, 1, 0, 0, 0, 1, 10, 32'hCAFE,   32'hCAFE,     32'h2,         32'h2};
        vecs[5]  = '{1, 13, 14, 15, 0, 32'h3,     32'h9,         32'h0,         5, 0, 1, 1, 0, 0, 0, 1, 14, 32'h1234,   32'h3,        32'h1234,      32'h1234};
        vecs[6]  = '{1, 0, 0, 1, 0, 32'h0,        32'h0,         32'h0,         4, 0, 1, 1, 0, 0, 0, 1, 0,  32'hFFFF,   32'h0,        32'h0,         32'h0};
        vecs[7]  = '{1, 0, 15, 16, 31, 32'h0,     32'h1,         32'h0,         8, 0, 1, 1, 0, 0, 0, 0, 0,  32'h0,      32'h0,        32'h1,         32'h1};
        vecs[8]  = '{0, 1, 2, 3, 0, 32'h77,       32'h88,        32'h0,         1, 0, 1, 1, 0, 0, 0, 0, 0,  32'h0,      32'h77,       32'h88,        32'h88};
        vecs[9]  = '{1, 0, 20, 20, 0, 32'h0,      32'h5,         32'hABCD0000,  6, 1, 0, 1, 0, 0, 0, 0, 0,  32'h0,      32'h0,        32'hABCD0000,  32'h5};
        vecs[10] = '{1, 21, 22, 23, 0, 32'hFFFFFFFF, 32'h1,      32'h0,         7, 0, 1, 1, 0, 0, 0, 1, 24, 32'h999,    32'hFFFFFFFF, 32'h1,         32'h1};

        // Reset with a valid ADD presented
        idle_side();
        rst = 1'b1;
        load_id(1, 1, 2, 3, 4, 32'h55, 32'h66, 32'h77, 4'd1, 0, 1, 1, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", ex_valid, 0);
        chk("rst.alu_ctrl", ex_alu_ctrl, 0);
        chk("rst.data1", ex_data1, 0);
        chk("rst.data2", ex_data2, 0);
        chk("rst.store", ex_store_data, 0);
        chk("rst.shamt", ex_shamt, 0);
        chk("rst.rd", ex_rd, 0);
        chk("rst.reg_write", ex_reg_write, 0);
        chk("rst.lus", load_use_stall, 0);
        rst = 1'b0;
        idle_id();
        @(posedge clk);
        #1;

        // Vector table: each transfer follows a bubble so no hazard is in flight
        foreach (vecs[i]) begin
            load_id(vecs[i].v, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh,
                    vecs[i].rsd, vecs[i].rtd, vecs[i].imm, vecs[i].alu, vecs[i].asrc,
                    vecs[i].urt, vecs[i].rw, vecs[i].mr, vecs[i].mw, vecs[i].m2r);
            wb_reg_write = vecs[i].wbw; wb_rd = vecs[i].wbrd; wb_data = vecs[i].wbd;
            #1;
            chk($sformatf("v%0d.lus", i), load_use_stall, 0);
            @(posedge clk);
            #1;
            idle_id();
            idle_side();
            #1;
            chk($sformatf("v%0d.valid", i), ex_valid, vecs[i].v);
            chk($sformatf("v%0d.data1", i), ex_data1, vecs[i].e_d1);
            chk($sformatf("v%0d.data2", i), ex_data2, vecs[i].e_d2);
            chk($sformatf("v%0d.store", i), ex_store_data, vecs[i].e_sd);
            chk($sformatf("v%0d.shamt", i), ex_shamt, {1'b0, vecs[i].sh});
            chk($sformatf("v%0d.alu_ctrl", i), ex_alu_ctrl, vecs[i].v ? vecs[i].alu : 4'd0);
            chk($sformatf("v%0d.rd", i), ex_rd, vecs[i].rd);
            chk($sformatf("v%0d.reg_write", i), ex_reg_write, vecs[i].v & vecs[i].rw);
            chk($sformatf("v%0d.mem_read", i), ex_mem_read, vecs[i].v & vecs[i].mr);
            chk($sformatf("v%0d.mem_write", i), ex_mem_write, vecs[i].v & vecs[i].mw);
            chk($sformatf("v%0d.mem_to_reg", i), ex_mem_to_reg, vecs[i].v & vecs[i].m2r);
            @(posedge clk);
            #1;
        end

        // EX/MEM result beats MEM/WB for the same register
        load_id(1, 1, 2, 3, 0, 32'h5, 32'h6, 32'h0, 4'd1, 0, 1, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        load_id(1, 3, 2, 4, 0, 32'h0, 32'h6, 32'h0, 4'd1, 0, 1, 1, 0, 0, 0);
        wb_reg_write = 1; wb_rd = 3; wb_data = 32'h20;
        #1;
        chk("t2.lus", load_use_stall, FWD ? 1'b0 : 1'b1);
        @(posedge clk);
        #1;
        idle_id();
        mem_reg_write = 1; mem_rd = 3; mem_fwd_data = 32'h10;
        wb_reg_write = 1; wb_rd = 3; wb_data = 32'h20;
        #1;
        chk("t2.valid", ex_valid, FWD ? 1'b1 : 1'b0);
        chk("t2.data1", ex_data1, FWD ? 32'h10 : 32'h20);
        idle_side();
        @(posedge clk);
        #1;

        // Load-use: LW $5 in EX, dependent ADD $6,$5,$1 in ID
        load_id(1, 1, 5, 5, 0, 32'h3000, 32'h0, 32'h4, 4'd1, 1, 0, 1, 1, 0, 1);
        @(posedge clk);
        #1;
        load_id(1, 5, 1, 6, 0, 32'hBAD, 32'h1, 32'h0, 4'd1, 0, 1, 1, 0, 0, 0);
        #1;
        chk("t3.lus", load_use_stall, 1);
        take  = !load_use_stall;
        got_k = 99;
        t3_d1 = 0;
        t3_rd = 0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            if (take) idle_id();
            mem_reg_write = (k == 1); mem_rd = (k == 1) ? 5'd5 : 5'd0;
            mem_fwd_data  = (k == 1) ? 32'h3004 : 32'h0;
            wb_reg_write  = (k == 2); wb_rd = (k == 2) ? 5'd5 : 5'd0;
            wb_data       = (k == 2) ? 32'h5A5A : 32'h0;
            #1;
            if (ex_valid && got_k == 99) begin
                got_k = k;
                t3_d1 = ex_data1;
                t3_rd = ex_rd;
            end
            if (id_valid) take = !load_use_stall;
        end
        chk("t3.latency", got_k, FWD ? 32'd2 : 32'd3);
        chk("t3.data1", t3_d1, 32'h5A5A);
        chk("t3.rd", t3_rd, 6);
        idle_id();
        idle_side();
        @(posedge clk);
        #1;

        // Stall for three cycles while a WB to rs retires in the first
        load_id(1, 7, 8, 9, 0, 32'h1111, 32'h2222, 32'h0, 4'd1, 0, 1, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        idle_id();
        stall = 1; wb_reg_write = 1; wb_rd = 7; wb_data = 32'hABCD;
        @(posedge clk);
        #1;
        wb_reg_write = 0; wb_rd = 0; wb_data = 0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        stall = 0;
        #1;
        chk("t4.valid", ex_valid, 1);
        chk("t4.data1", ex_data1, 32'hABCD);
        chk("t4.data2", ex_data2, 32'h2222);
        chk("t4.rd", ex_rd, 9);
        @(posedge clk);
        #1;

        // Flush wins over stall
        load_id(1, 1, 2, 10, 0, 32'h1, 32'h2, 32'h0, 4'd1, 0, 1, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        load_id(1, 2, 3, 11, 0, 32'h3, 32'h4, 32'h0, 4'd2, 0, 1, 1, 0, 0, 0);
        flush = 1; stall = 1;
        @(posedge clk);
        #1;
        idle_id();
        idle_side();
        #1;
        chk("t5.valid", ex_valid, 0);
        chk("t5.reg_write", ex_reg_write, 0);
        chk("t5.alu_ctrl", ex_alu_ctrl, 0);

        // Reset during a stall with a load-use pending
        @(posedge clk);
        #1;
        load_id(1, 1, 5, 5, 0, 32'h3000, 32'h0, 32'h4, 4'd1, 1, 0, 1, 1, 0, 1);
        @(posedge clk);
        #1;
        load_id(1, 5, 0, 6, 0, 32'h0, 32'h0, 32'h0, 4'd1, 0, 0, 1, 0, 0, 0);
        stall = 1;
        #1;
        chk("t5r.lus_before", load_use_stall, 1);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        #1;
        chk("t5r.lus_after", load_use_stall, 0);
        chk("t5r.valid", ex_valid, 0);
        idle_id();
        idle_side();
        @(posedge clk);
        #1;

        // $0 never forwarded; SLL by 31
        load_id(1, 0, 3, 4, 31, 32'h0, 32'h80, 32'h0, 4'd8, 0, 1, 1, 0, 0, 0);
        mem_reg_write = 1; mem_rd = 0; mem_fwd_data = 32'hFFFF;
        wb_reg_write = 1; wb_rd = 0; wb_data = 32'hFFFF;
        #1;
        chk("t6.lus", load_use_stall, 0);
        @(posedge clk);
        #1;
        idle_id();
        #1;
        chk("t6.data1", ex_data1, 0);
        chk("t6.data2", ex_data2, 32'h80);
        chk("t6.shamt", ex_shamt, 6'd31);
        chk("t6.alu_ctrl", ex_alu_ctrl, 4'd8);
        idle_side();
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
